// File: rtl/modinv_helper_final.sv
// ============================================================================
// modinv_helper_final
// Unloads the modular invertor: writes x = r mod q (r in [0, 2q)) by a
// compare-by-subtraction pass followed by a select-and-write pass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module modinv_helper_final #(
  parameter int OPERAND_NUM_WORDS = 8,
  parameter int OPERAND_ADDR_BITS = 3,
  parameter int BUFFER_NUM_WORDS  = 9,
  parameter int BUFFER_ADDR_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  output logic                         rdy,
  output logic [BUFFER_ADDR_BITS-1:0]  r_addr,
  input  logic [31:0]                  r_din,
  output logic [OPERAND_ADDR_BITS-1:0] q_addr,
  input  logic [31:0]                  q_din,
  output logic [OPERAND_ADDR_BITS-1:0] x_addr,
  output logic                         x_wren,
  output logic [31:0]                  x_dout
);

  localparam int CNT_W = BUFFER_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(BUFFER_NUM_WORDS);
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(OPERAND_NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic                           borrow, borrow_nxt;
  logic                           sel, sel_nxt;
  logic                           q_hi, q_hi_nxt;
  logic [OPERAND_ADDR_BITS-1:0]   wr_idx;
  logic                           consume;
  logic [31:0]                    q_eff;
  logic [32:0]                    diff;

  // cnt is the address issued this cycle; the word consumed is cnt-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      sel    <= 1'b0;
      q_hi   <= 1'b0;
      wr_idx <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      borrow <= borrow_nxt;
      sel    <= sel_nxt;
      q_hi   <= q_hi_nxt;
      wr_idx <= cnt[OPERAND_ADDR_BITS-1:0];
    end
  end

  assign consume = (state != S_IDLE) && (cnt != '0);
  assign q_eff   = q_hi ? 32'd0 : q_din;
  assign diff    = {1'b0, r_din} - {1'b0, q_eff} - {32'd0, borrow};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    borrow_nxt = borrow;
    sel_nxt    = sel;
    q_hi_nxt   = (state == S_CMP) && (cnt >= M_LAST);
    rdy        = 1'b0;
    r_addr     = '0;
    q_addr     = '0;
    x_wren     = 1'b0;
    x_addr     = '0;
    x_dout     = 32'd0;

    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (ena) begin
          state_nxt  = S_CMP;
          cnt_nxt    = '0;
          borrow_nxt = 1'b0;
        end
      end
      S_CMP: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt < N_LAST) r_addr = cnt[BUFFER_ADDR_BITS-1:0];
        if (cnt < M_LAST) q_addr = cnt[OPERAND_ADDR_BITS-1:0];
        if (consume) borrow_nxt = diff[32];
        if (cnt == N_LAST) begin
          sel_nxt    = ~diff[32];
          borrow_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = S_WR;
        end
      end
      S_WR: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt < M_LAST) begin
          r_addr = BUFFER_ADDR_BITS'(cnt);
          q_addr = cnt[OPERAND_ADDR_BITS-1:0];
        end
        if (consume) begin
          borrow_nxt = diff[32];
          x_wren     = 1'b1;
          x_addr     = wr_idx;
          x_dout     = sel ? diff[31:0] : r_din;
        end
        if (cnt == M_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_modinv_helper_final.sv
// ============================================================================
// tb_modinv_helper_final
// Self-checking bench: wide-integer reference of r mod q plus cycle checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_modinv_helper_final;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        rdy;
  logic [3:0]  r_addr;
  logic [31:0] r_din;
  logic [2:0]  q_addr;
  logic [31:0] q_din;
  logic [2:0]  x_addr;
  logic        x_wren;
  logic [31:0] x_dout;

  modinv_helper_final #(
    .OPERAND_NUM_WORDS(8), .OPERAND_ADDR_BITS(3),
    .BUFFER_NUM_WORDS(9),  .BUFFER_ADDR_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy),
    .r_addr(r_addr), .r_din(r_din), .q_addr(q_addr), .q_din(q_din),
    .x_addr(x_addr), .x_wren(x_wren), .x_dout(x_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] r_mem [16];
  logic [31:0] q_mem [8];

  always @(posedge clk) begin
    r_din <= r_mem[r_addr];
    q_din <= q_mem[q_addr];
  end

  int checks = 0;
  int errors = 0;

  logic        rdy_log   [64];
  logic        wren_log  [64];
  logic [2:0]  addr_log  [64];
  logic [31:0] dout_log  [64];
  logic [3:0]  raddr_log [64];
  logic [2:0]  qaddr_log [64];

  localparam logic [255:0] Q_STD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF1;

  // Reference: fully reduced result of r in [0,2q) as plain wide arithmetic
  function automatic logic [255:0] ref_x(input logic [287:0] r, input logic [255:0] q);
    logic [287:0] qq;
    qq = {32'd0, q};
    if (r >= qq) return 256'(r - qq);
    return r[255:0];
  endfunction

  task automatic load(input logic [287:0] r, input logic [255:0] q);
    for (int i = 0; i < 16; i++) r_mem[i] = (i < 9) ? r[32*i +: 32] : 32'd0;
    for (int i = 0; i < 8; i++)  q_mem[i] = q[32*i +: 32];
  endtask

  task automatic run_collect(input int ncyc, input bit hold, input int pulse_at);
    @(negedge clk);
    rdy_log[0] = rdy;
    ena = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!hold) ena = (k == pulse_at);
      rdy_log[k]   = rdy;
      wren_log[k]  = x_wren;
      addr_log[k]  = x_addr;
      dout_log[k]  = x_dout;
      raddr_log[k] = r_addr;
      qaddr_log[k] = q_addr;
    end
    ena = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    load(288'd0, Q_STD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || x_wren !== 1'b0 || r_addr !== 4'd0 || q_addr !== 3'd0 ||
        x_addr !== 3'd0 || x_dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold rdy=%b wren=%b ra=%0d qa=%0d xa=%0d xd=%h want rdy=1 rest 0",
               rdy, x_wren, r_addr, q_addr, x_addr, x_dout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || x_wren !== 1'b0 || x_dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_release rdy=%b wren=%b xd=%h want 1/0/0", rdy, x_wren, x_dout);
    end
  endtask

  task automatic test_values();
    logic [287:0] rv [5];
    logic [287:0] r, rnd;
    logic [255:0] q, xe;
    rv[0] = {32'd0, Q_STD} + 288'd5;
    rv[1] = {32'd0, Q_STD} - 288'd1;
    rv[2] = {32'd0, Q_STD};
    rv[3] = 288'd0;
    rv[4] = 288'd1 << 256;
    for (int t = 0; t < 13; t++) begin
      if (t < 5) begin
        q = Q_STD;
        r = rv[t];
      end else begin
        for (int i = 0; i < 8; i++) q[32*i +: 32] = $urandom;
        if (t < 9) q = Q_STD;
        q[255] = (t % 2 == 0) ? 1'b1 : q[255];
        q[0]   = 1'b1;
        for (int i = 0; i < 9; i++) rnd[32*i +: 32] = $urandom;
        r = rnd % ({32'd0, q} << 1);
      end
      xe = ref_x(r, q);
      load(r, q);
      run_collect(20, 1'b0, 0);
      checks++;
      if (rdy_log[0] !== 1'b1) begin
        errors++;
        $display("FAIL val%0d_rdy_start got=%b want=1", t, rdy_log[0]);
      end
      for (int k = 1; k <= 20; k++) begin
        checks++;
        if (rdy_log[k] !== (k == 20)) begin
          errors++;
          $display("FAIL val%0d_rdy cyc=%0d got=%b want=%b", t, k, rdy_log[k], (k == 20));
        end
        checks++;
        if (wren_log[k] !== (k >= 12 && k <= 19)) begin
          errors++;
          $display("FAIL val%0d_wren cyc=%0d got=%b want=%b", t, k, wren_log[k], (k >= 12 && k <= 19));
        end else if (k >= 12 && k <= 19) begin
          checks++;
          if (addr_log[k] !== 3'(k - 12) || dout_log[k] !== xe[32*(k-12) +: 32]) begin
            errors++;
            $display("FAIL val%0d_write cyc=%0d addr=%0d data=%h want addr=%0d data=%h",
                     t, k, addr_log[k], dout_log[k], k - 12, xe[32*(k-12) +: 32]);
          end
        end else begin
          checks++;
          if (dout_log[k] !== 32'd0) begin
            errors++;
            $display("FAIL val%0d_dout_idle cyc=%0d got=%h want=0", t, k, dout_log[k]);
          end
        end
      end
    end
  endtask

  task automatic test_cycle();
    logic [255:0] xe;
    load({32'd0, Q_STD} + 288'd5, Q_STD);
    xe = ref_x({32'd0, Q_STD} + 288'd5, Q_STD);
    run_collect(24, 1'b0, 5);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (raddr_log[k] !== 4'(k - 1) || qaddr_log[k] !== ((k - 1 < 8) ? 3'(k - 1) : 3'd0)) begin
        errors++;
        $display("FAIL cyc_cmp_addr cyc=%0d r=%0d q=%0d want r=%0d q=%0d", k, raddr_log[k],
                 qaddr_log[k], k - 1, (k - 1 < 8) ? k - 1 : 0);
      end
    end
    for (int k = 11; k <= 18; k++) begin
      checks++;
      if (raddr_log[k] !== 4'(k - 11) || qaddr_log[k] !== 3'(k - 11)) begin
        errors++;
        $display("FAIL cyc_wr_addr cyc=%0d r=%0d q=%0d want %0d", k, raddr_log[k], qaddr_log[k], k - 11);
      end
    end
    checks++;
    if (xe !== 256'd5 || dout_log[12] !== 32'd5 || dout_log[13] !== 32'd0) begin
      errors++;
      $display("FAIL cyc_result w0=%h w1=%h want 5/0", dout_log[12], dout_log[13]);
    end
    for (int k = 20; k <= 24; k++) begin
      checks++;
      if (rdy_log[k] !== 1'b1 || wren_log[k] !== 1'b0) begin
        errors++;
        $display("FAIL cyc_busy_ena_ignored cyc=%0d rdy=%b wren=%b want 1/0", k, rdy_log[k], wren_log[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] xe;
    load({32'd0, Q_STD} + 288'd5, Q_STD);
    xe = ref_x({32'd0, Q_STD} + 288'd5, Q_STD);
    run_collect(40, 1'b1, 0);
    checks++;
    if (rdy_log[20] !== 1'b1 || rdy_log[21] !== 1'b0 || rdy_log[40] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rdy c20=%b c21=%b c40=%b want 1/0/1", rdy_log[20], rdy_log[21], rdy_log[40]);
    end
    for (int k = 21; k <= 40; k++) begin
      checks++;
      if (wren_log[k] !== (k >= 32 && k <= 39) ||
          (wren_log[k] && (addr_log[k] !== 3'(k - 32) || dout_log[k] !== xe[32*(k-32) +: 32]))) begin
        errors++;
        $display("FAIL b2b_second cyc=%0d wren=%b addr=%0d data=%h", k, wren_log[k], addr_log[k], dout_log[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0] xe;
    logic         pre_wren;
    load({32'd0, Q_STD} + 288'd5, Q_STD);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      ena = 1'b0;
    end
    pre_wren = x_wren;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pre_wren !== 1'b1 || rdy !== 1'b1 || x_wren !== 1'b0 || r_addr !== 4'd0 ||
        q_addr !== 3'd0 || x_addr !== 3'd0 || x_dout !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async pre_wren=%b rdy=%b wren=%b ra=%0d qa=%0d xa=%0d xd=%h",
               pre_wren, rdy, x_wren, r_addr, q_addr, x_addr, x_dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load({32'd0, Q_STD} - 288'd1, Q_STD);
    xe = ref_x({32'd0, Q_STD} - 288'd1, Q_STD);
    run_collect(20, 1'b0, 0);
    for (int k = 12; k <= 19; k++) begin
      checks++;
      if (wren_log[k] !== 1'b1 || addr_log[k] !== 3'(k - 12) || dout_log[k] !== xe[32*(k-12) +: 32]) begin
        errors++;
        $display("FAIL midrst_rerun cyc=%0d wren=%b addr=%0d data=%h want data=%h",
                 k, wren_log[k], addr_log[k], dout_log[k], xe[32*(k-12) +: 32]);
      end
    end
    checks++;
    if (rdy_log[20] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rdy got=%b want=1", rdy_log[20]);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_cycle();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modinv_helper_final.md
# modinv_helper_final

Output-side helper of the modular invertor: reads the final result buffer `r` (BUFFER_NUM_WORDS words, value in [0, 2q)) and modulus `q` (OPERAND_NUM_WORDS words). It writes the fully reduced operand x = r mod q into the output operand memory. It performs a compare-by-subtraction pass, then a select-and-write pass. It is the unloading counterpart of the init helper, which fills r/s/u/v from a/q.

## Interface
- OPERAND_NUM_WORDS, 8, words in q and x (M)
- OPERAND_ADDR_BITS, 3, address width of q and x memories
- BUFFER_NUM_WORDS, 9, words in r buffer (N, N > M)
- BUFFER_ADDR_BITS, 4, address width of r buffer
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  start request, sampled only while rdy=1
- rdy  out  1  idle/done flag
- r_addr  out  BUFFER_ADDR_BITS  r buffer read address
- r_din  in  32  r buffer read data, 1-cycle synchronous latency
- q_addr  out  OPERAND_ADDR_BITS  modulus read address
- q_din  in  32  modulus read data, 1-cycle latency
- x_addr  out  OPERAND_ADDR_BITS  output operand write address
- x_wren  out  1  output operand write enable
- x_dout  out  32  output operand write data

## Operation
- Word order: little-endian; index 0 is least significant.
- q is zero-extended to N words. For index ≥ M, q_addr is driven 0 and the consumed q word is forced to 0. The mask is taken from a 1-cycle-delayed "index ≥ M" flag.
- States: IDLE, CMP, WR.
- IDLE: rdy=1, all addresses 0, x_wren=0, x_dout=0. Accepting ena=1 enters CMP and clears borrow.
- CMP: read r[i], q[i] for i=0..N-1. Compute d_i = r_i − q_i − borrow as a 33-bit difference. borrow ← bit 32. No writes. After the last word: sel ← ~borrow (sel=1 means r ≥ q). Clear borrow. Enter WR.
- WR: read r[j], q[j] for j=0..M-1 and recompute d_j with the same borrow chain. Write x[j] = sel ? d_j : r_j. After the last write, return to IDLE.
- Differences are not stored; pass 2 recomputes them.
- Upper r words (index ≥ M) only affect the pass-1 borrow and are never written.
- ena while busy is ignored; it is not queued.
- Precondition: r < 2q. Behaviour outside this range is defined as the same datapath with no extra correction. The bench does not check it.

## Timing
- Cycle 0 is the clock edge where ena=1 and rdy=1 are sampled. rdy drops after this edge.
- Cycles 1..N: r_addr = q_addr (masked) = k−1. Data is consumed in cycles 2..N+1.
- sel is latched at the end of cycle N+1.
- Cycles N+2..N+M+1: read addresses 0..M−1.
- Cycles N+3..N+M+2: x_wren=1, x_addr=j, x_dout valid in the same cycle.
- Write sequence is contiguous: one word per cycle, addresses 0..M−1 ascending, no gaps.
- rdy returns high in cycle N+M+3. Busy time is N+M+2 cycles (19 for defaults).
- A new ena may be accepted in the first cycle rdy=1 (back-to-back allowed).
- Reset values: state IDLE, rdy=1, r_addr=q_addr=x_addr=0, x_wren=0, x_dout=0, borrow=0, sel=0.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). A partial write of x is left as-is. The next ena performs a full run.
- x_wren is never asserted outside WR. x_dout is 0 whenever x_wren=0.

## Test plan
In all scenarios below, q = 2^256 − 15: word0 = 0xFFFFFFF1, words 1..7 = 0xFFFFFFFF.
- r = q + 5 -> sel=1, x = 5 (word0 = 0x00000005, others 0); rdy high at cycle 20.
- r = q − 1 -> sel=0, x = q − 1 (word0 = 0xFFFFFFF0, others 0xFFFFFFFF).
- r = q -> x = 0; r = 0 -> x = 0. Both exercise exact-equality and zero boundaries.
- r = 2^256 (word8 = 1, words 0..7 = 0) -> borrow resolved by the zero-extended top word, sel=1, x word0 = 0x0000000F, others 0.
- Cycle check: x_wren high exactly in cycles 12..19 with x_addr 0..7. ena pulsed during busy -> ignored. ena held high -> second run starts at cycle 20 and produces an identical result.
- rst_n low during cycle 14 -> x_wren=0 and rdy=1 immediately, all addresses 0. After release, ena runs to a correct result with no residual borrow or sel.
